byte_stream_deser: RTL and testbench

Parametrised, handshaked successor to the single-shot byte de-/serializer in the UART debug path. One transfer, started by a pulse, does two things at the same time:
- serializes a latched parallel register into a valid/ready word stream toward the UART TX side;
- deserializes a valid/ready word stream from the UART RX side into a parallel register.

Word width, register depth and word order are configurable. Each direction supports backpressure, and the block reports a clean completion or abort status to the debug-module interface logic.

---
 rtl/byte_stream_pkg.sv | 19 +
 rtl/stream_word_counter.sv | 39 +++
 rtl/byte_stream_deser.sv | 146 ++++++++++++++
 tb/tb_byte_stream_deser.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/byte_stream_pkg.sv
// Shared types and helpers for the byte stream de-/serializer.
// Word-count and word-order arithmetic lives here so TX and RX map words identically.
package byte_stream_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   function automatic int n_words(input int nb, input int word_w);
      return (nb + word_w - 1) / word_w;
   endfunction

   function automatic int word_index(input int k, input int n, input logic msb_first);
      return msb_first ? (n - 1 - k) : k;
   endfunction

endpackage

// File: rtl/stream_word_counter.sv
// Saturating word counter: counts handshakes up to n, cleared when a transfer starts.
// done_next_o lets the FSM leave RUN on the same edge as the final handshake.
module stream_word_counter #(
   parameter int CNT_W = 4
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clr_i,
   input  logic             inc_i,
   input  logic [CNT_W-1:0] n_i,
   output logic [CNT_W-1:0] cnt_o,
   output logic             done_o,
   output logic             done_next_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && (cnt_q < n_i)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o       = cnt_q;
   assign done_o      = (cnt_q == n_i);
   assign done_next_o = (cnt_d == n_i);

endmodule

// File: rtl/byte_stream_deser.sv
// Handshaked parallel<->stream transfer: serializes a latched register to TX while
// deserializing RX words into REG_O, reporting completion or abort with one-cycle pulses.
module byte_stream_deser
   import byte_stream_pkg::*;
#(
   parameter int WORD_W    = 8,
   parameter int MAX_WORDS = 8,
   parameter int NB_W      = $clog2(WORD_W * MAX_WORDS + 1)
) (
   input  logic                          CLK_I,
   input  logic                          RST_NI,
   input  logic                          START_I,
   input  logic                          ABORT_I,
   input  logic [NB_W-1:0]               NUM_BITS_I,
   input  logic                          MSB_FIRST_I,
   input  logic [WORD_W*MAX_WORDS-1:0]   REG_I,
   output logic [WORD_W*MAX_WORDS-1:0]   REG_O,
   output logic [WORD_W-1:0]             TX_DATA_O,
   output logic                          TX_VALID_O,
   input  logic                          TX_READY_I,
   input  logic [WORD_W-1:0]             RX_DATA_I,
   input  logic                          RX_VALID_I,
   output logic                          RX_READY_O,
   output logic                          BUSY_O,
   output logic                          DONE_O,
   output logic                          ABORTED_O
);

   localparam int REG_W = WORD_W * MAX_WORDS;
   localparam int CNT_W = $clog2(MAX_WORDS + 1);
   localparam int IDX_W = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;

   state_e              state_q, state_d;
   logic [NB_W-1:0]     nb_q, nb_start;
   logic [CNT_W-1:0]    n_q, n_start;
   logic                msb_q;
   logic [REG_W-1:0]    shadow_q, reg_q, reg_d;
   logic [REG_W-1:0]    start_mask, done_mask;
   logic                aborted_q, aborted_d;
   logic                start_acc, go_done;
   logic [CNT_W-1:0]    tx_cnt, rx_cnt;
   logic                tx_done, tx_done_next, rx_done, rx_done_next;
   logic                tx_valid, rx_ready, tx_hs, rx_hs;
   logic [IDX_W-1:0]    tx_widx, rx_widx;
   logic [WORD_W-1:0]   shadow_words [MAX_WORDS];

   assign nb_start = (NUM_BITS_I > NB_W'(REG_W)) ? NB_W'(REG_W) : NUM_BITS_I;
   assign n_start  = CNT_W'(n_words(int'(nb_start), WORD_W));

   // Bits at or above nb never leave the block nor survive in REG_O at completion.
   for (genvar gi = 0; gi < REG_W; gi++) begin : g_bit
      assign start_mask[gi] = (NB_W'(gi) < nb_start);
      assign done_mask[gi]  = (NB_W'(gi) < nb_q);
   end

   assign tx_widx = IDX_W'(word_index(int'(tx_cnt), int'(n_q), msb_q));
   assign rx_widx = IDX_W'(word_index(int'(rx_cnt), int'(n_q), msb_q));

   for (genvar gi = 0; gi < MAX_WORDS; gi++) begin : g_word
      logic [WORD_W-1:0] wr_word;
      assign shadow_words[gi] = shadow_q[gi*WORD_W +: WORD_W];
      assign wr_word = (rx_hs && (rx_widx == IDX_W'(gi))) ? RX_DATA_I
                                                           : reg_q[gi*WORD_W +: WORD_W];
      assign reg_d[gi*WORD_W +: WORD_W] =
         start_acc ? '0 :
         go_done   ? (wr_word & done_mask[gi*WORD_W +: WORD_W]) : wr_word;
   end

   assign tx_valid = (state_q == RUN) && !tx_done;
   assign rx_ready = (state_q == RUN) && !rx_done;
   assign tx_hs    = tx_valid && TX_READY_I;
   assign rx_hs    = rx_ready && RX_VALID_I;

   stream_word_counter #(.CNT_W(CNT_W)) u_tx_cnt (
      .clk_i(CLK_I), .rst_ni(RST_NI), .clr_i(start_acc), .inc_i(tx_hs), .n_i(n_q),
      .cnt_o(tx_cnt), .done_o(tx_done), .done_next_o(tx_done_next)
   );

   stream_word_counter #(.CNT_W(CNT_W)) u_rx_cnt (
      .clk_i(CLK_I), .rst_ni(RST_NI), .clr_i(start_acc), .inc_i(rx_hs), .n_i(n_q),
      .cnt_o(rx_cnt), .done_o(rx_done), .done_next_o(rx_done_next)
   );

   always_comb begin
      state_d   = state_q;
      aborted_d = 1'b0;
      start_acc = 1'b0;
      go_done   = 1'b0;
      case (state_q)
         IDLE: begin
            if (START_I) begin
               start_acc = 1'b1;
               if (n_start == '0) begin
                  state_d = DONE;
                  go_done = 1'b1;
               end else begin
                  state_d = RUN;
               end
            end
         end
         RUN: begin
            // Abort wins over a completion landing on the same edge.
            if (ABORT_I) begin
               state_d   = IDLE;
               aborted_d = 1'b1;
            end else if (tx_done_next && rx_done_next) begin
               state_d = DONE;
               go_done = 1'b1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK_I) begin
      if (!RST_NI) begin
         state_q   <= IDLE;
         nb_q      <= '0;
         n_q       <= '0;
         msb_q     <= 1'b0;
         shadow_q  <= '0;
         reg_q     <= '0;
         aborted_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         aborted_q <= aborted_d;
         reg_q     <= reg_d;
         if (start_acc) begin
            nb_q     <= nb_start;
            n_q      <= n_start;
            msb_q    <= MSB_FIRST_I;
            shadow_q <= REG_I & start_mask;
         end
      end
   end

   assign REG_O      = reg_q;
   assign TX_DATA_O  = tx_valid ? shadow_words[tx_widx] : '0;
   assign TX_VALID_O = tx_valid;
   assign RX_READY_O = rx_ready;
   assign BUSY_O     = (state_q != IDLE);
   assign DONE_O     = (state_q == DONE);
   assign ABORTED_O  = aborted_q;

endmodule

// File: tb/tb_byte_stream_deser.sv
// Directed bench for byte_stream_deser: TX words checked against a scoreboard queue,
// RX words fed from a queue, status and REG_O checked at each step.
module tb_byte_stream_deser;

   localparam int WORD_W    = 8;
   localparam int MAX_WORDS = 8;
   localparam int REG_W     = WORD_W * MAX_WORDS;
   localparam int NB_W      = $clog2(REG_W + 1);

   logic              CLK_I = 1'b0;
   logic              RST_NI = 1'b0;
   logic              START_I = 1'b0;
   logic              ABORT_I = 1'b0;
   logic [NB_W-1:0]   NUM_BITS_I = '0;
   logic              MSB_FIRST_I = 1'b0;
   logic [REG_W-1:0]  REG_I = '0;
   logic [REG_W-1:0]  REG_O;
   logic [WORD_W-1:0] TX_DATA_O;
   logic              TX_VALID_O;
   logic              TX_READY_I = 1'b0;
   logic [WORD_W-1:0] RX_DATA_I = '0;
   logic              RX_VALID_I = 1'b0;
   logic              RX_READY_O;
   logic              BUSY_O;
   logic              DONE_O;
   logic              ABORTED_O;

   always #5 CLK_I = ~CLK_I;

   byte_stream_deser #(.WORD_W(WORD_W), .MAX_WORDS(MAX_WORDS), .NB_W(NB_W)) dut (
      .CLK_I(CLK_I), .RST_NI(RST_NI), .START_I(START_I), .ABORT_I(ABORT_I),
      .NUM_BITS_I(NUM_BITS_I), .MSB_FIRST_I(MSB_FIRST_I), .REG_I(REG_I), .REG_O(REG_O),
      .TX_DATA_O(TX_DATA_O), .TX_VALID_O(TX_VALID_O), .TX_READY_I(TX_READY_I),
      .RX_DATA_I(RX_DATA_I), .RX_VALID_I(RX_VALID_I), .RX_READY_O(RX_READY_O),
      .BUSY_O(BUSY_O), .DONE_O(DONE_O), .ABORTED_O(ABORTED_O)
   );

   int   pass_cnt = 0;
   int   fail_cnt = 0;
   int   total_cnt = 0;
   logic [7:0] tx_q [$];
   logic [7:0] rx_q [$];
   int   cyc = 0;
   int   done_cyc = 0;
   int   done_cnt = 0;
   int   abort_cnt = 0;
   bit   early = 1'b0;
   bit   tx_rand = 1'b0;
   bit   tx_ready_fix = 1'b1;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // TX scoreboard and stall-stability monitor, sampled mid-cycle.
   logic       prev_stall = 1'b0;
   logic [7:0] prev_data = '0;
   always @(negedge CLK_I) begin
      logic [7:0] exp_w;
      if (RST_NI && TX_VALID_O) begin
         if (prev_stall) chk("tx_stable", 64'(TX_DATA_O), 64'(prev_data));
         if (TX_READY_I) begin
            if (tx_q.size() == 0) begin
               chk("tx_unexpected_word", 64'(TX_VALID_O), 64'd0);
            end else begin
               exp_w = tx_q.pop_front();
               chk("tx_word", 64'(TX_DATA_O), 64'(exp_w));
            end
            prev_stall = 1'b0;
         end else begin
            prev_stall = 1'b1;
            prev_data  = TX_DATA_O;
         end
      end else begin
         prev_stall = 1'b0;
      end
   end

   task automatic tick();
      bit hs;
      hs = RX_VALID_I && RX_READY_O;
      @(posedge CLK_I);
      #1;
      if (hs && rx_q.size() > 0) void'(rx_q.pop_front());
      RX_VALID_I = (rx_q.size() > 0);
      RX_DATA_I  = (rx_q.size() > 0) ? rx_q[0] : 8'h00;
      TX_READY_I = tx_rand ? ($urandom_range(0, 2) == 0) : tx_ready_fix;
      cyc++;
      if (DONE_O) begin
         done_cnt++;
         done_cyc = cyc;
         if (tx_q.size() != 0) early = 1'b1;
      end
      if (ABORTED_O) abort_cnt++;
   endtask

   task automatic start_xfer(input logic [NB_W-1:0] nb, input logic msb, input logic [63:0] r);
      NUM_BITS_I  = nb;
      MSB_FIRST_I = msb;
      REG_I       = r;
      START_I     = 1'b1;
      cyc = 0; done_cnt = 0; done_cyc = 0; abort_cnt = 0; early = 1'b0;
      tick();
      START_I = 1'b0;
   endtask

   task automatic wait_end(input string tag, input int limit);
      int n = 0;
      while (!DONE_O && !ABORTED_O && n < limit) begin
         tick();
         n++;
      end
      chk({tag, "_finished"}, 64'(DONE_O | ABORTED_O), 64'd1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) tick();
      chk("rst_reg_o", REG_O, 64'd0);
      chk("rst_tx_data", 64'(TX_DATA_O), 64'd0);
      chk("rst_tx_valid", 64'(TX_VALID_O), 64'd0);
      chk("rst_rx_ready", 64'(RX_READY_O), 64'd0);
      chk("rst_busy", 64'(BUSY_O), 64'd0);
      chk("rst_done", 64'(DONE_O), 64'd0);
      chk("rst_aborted", 64'(ABORTED_O), 64'd0);
      RST_NI = 1'b1;
      tick();

      // LSB-first round trip
      tx_ready_fix = 1'b1;
      rx_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
      tx_q = '{8'h44, 8'h33, 8'h22, 8'h11};
      start_xfer(7'd32, 1'b0, 64'h1122_3344);
      chk("lsb_valid_after_start", 64'(TX_VALID_O), 64'd1);
      chk("lsb_ready_after_start", 64'(RX_READY_O), 64'd1);
      wait_end("lsb", 20);
      chk("lsb_done_cycle", 64'(done_cyc), 64'd5);
      chk("lsb_busy_in_done", 64'(BUSY_O), 64'd1);
      chk("lsb_reg_o", REG_O, 64'hDDCC_BBAA);
      tick();
      chk("lsb_idle_busy", 64'(BUSY_O), 64'd0);
      chk("lsb_done_single", 64'(done_cnt), 64'd1);
      repeat (3) tick();
      chk("lsb_reg_hold", REG_O, 64'hDDCC_BBAA);
      chk("lsb_tx_all_sent", 64'(tx_q.size()), 64'd0);

      // MSB-first with a partial word
      rx_q = '{8'hFF, 8'hFF};
      tx_q = '{8'h0A, 8'hBC};
      start_xfer(7'd12, 1'b1, 64'h0ABC);
      wait_end("msb", 20);
      chk("msb_reg_o", REG_O, 64'h0FFF);
      chk("msb_tx_all_sent", 64'(tx_q.size()), 64'd0);
      tick();

      // Backpressure on TX, RX finishes first
      tx_rand = 1'b1;
      rx_q = '{8'h01, 8'h02, 8'h03, 8'h04};
      tx_q = '{8'hBE, 8'hBA, 8'hFE, 8'hCA};
      start_xfer(7'd32, 1'b0, 64'hCAFE_BABE);
      wait_end("bp", 300);
      chk("bp_no_early_done", 64'(early), 64'd0);
      chk("bp_reg_o", REG_O, 64'h0403_0201);
      chk("bp_tx_all_sent", 64'(tx_q.size()), 64'd0);
      tx_rand = 1'b0;
      tick();

      // Zero-length transfer
      start_xfer(7'd0, 1'b0, 64'hFFFF);
      chk("zero_done", 64'(DONE_O), 64'd1);
      chk("zero_tx_valid", 64'(TX_VALID_O), 64'd0);
      chk("zero_rx_ready", 64'(RX_READY_O), 64'd0);
      chk("zero_reg_cleared", REG_O, 64'd0);
      tick();
      chk("zero_done_gone", 64'(DONE_O), 64'd0);
      chk("zero_idle", 64'(BUSY_O), 64'd0);

      // Oversized NUM_BITS clamps to 8 words
      rx_q = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17};
      tx_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
      start_xfer(7'd100, 1'b0, 64'h8877_6655_4433_2211);
      wait_end("clamp", 30);
      chk("clamp_done_cycle", 64'(done_cyc), 64'd9);
      chk("clamp_reg_o", REG_O, 64'h1716_1514_1312_1110);
      chk("clamp_tx_all_sent", 64'(tx_q.size()), 64'd0);
      tick();

      // Abort after 2 of 4 words
      rx_q = '{8'hA1, 8'hA2};
      tx_q = '{8'h0A, 8'h0B};
      start_xfer(7'd32, 1'b0, 64'h0D0C_0B0A);
      tick();
      tick();
      TX_READY_I = 1'b0;
      tx_ready_fix = 1'b0;
      ABORT_I = 1'b1;
      tick();
      ABORT_I = 1'b0;
      chk("abort_pulse", 64'(ABORTED_O), 64'd1);
      chk("abort_idle", 64'(BUSY_O), 64'd0);
      chk("abort_tx_valid", 64'(TX_VALID_O), 64'd0);
      chk("abort_rx_ready", 64'(RX_READY_O), 64'd0);
      chk("abort_reg_partial", REG_O, 64'hA2A1);
      tick();
      chk("abort_pulse_gone", 64'(ABORTED_O), 64'd0);
      chk("abort_no_done", 64'(done_cnt), 64'd0);
      chk("abort_tx_sent", 64'(tx_q.size()), 64'd0);
      tx_ready_fix = 1'b1;
      tick();
      rx_q = '{8'h5A, 8'h5B};
      tx_q = '{8'h34, 8'h12};
      start_xfer(7'd16, 1'b0, 64'h1234);
      wait_end("after_abort", 20);
      chk("after_abort_done_cycle", 64'(done_cyc), 64'd3);
      chk("after_abort_reg_o", REG_O, 64'h5B5A);
      tick();

      // Reset in the middle of a transfer
      rx_q = '{8'hC1, 8'hC2, 8'hC3};
      tx_q = '{8'h11, 8'h22, 8'h33};
      start_xfer(7'd24, 1'b0, 64'h33_2211);
      tick();
      RST_NI = 1'b0;
      tick();
      chk("mrst_reg_o", REG_O, 64'd0);
      chk("mrst_tx_data", 64'(TX_DATA_O), 64'd0);
      chk("mrst_tx_valid", 64'(TX_VALID_O), 64'd0);
      chk("mrst_rx_ready", 64'(RX_READY_O), 64'd0);
      chk("mrst_busy", 64'(BUSY_O), 64'd0);
      chk("mrst_done", 64'(DONE_O), 64'd0);
      chk("mrst_aborted", 64'(ABORTED_O), 64'd0);
      tx_q.delete();
      rx_q.delete();
      RST_NI = 1'b1;
      tick();
      tick();
      chk("mrst_no_pulses", 64'(done_cnt + abort_cnt), 64'd0);

      // START during RUN is ignored
      rx_q = '{8'hE1, 8'hE2, 8'hE3};
      tx_q = '{8'h21, 8'h43, 8'h65};
      start_xfer(7'd24, 1'b0, 64'h65_4321);
      START_I = 1'b1;
      NUM_BITS_I = 7'd8;
      REG_I = 64'hFFFF_FFFF;
      MSB_FIRST_I = 1'b1;
      tick();
      START_I = 1'b0;
      wait_end("restart", 20);
      chk("restart_done_cycle", 64'(done_cyc), 64'd4);
      chk("restart_reg_o", REG_O, 64'hE3_E2E1);
      chk("restart_tx_all_sent", 64'(tx_q.size()), 64'd0);
      tick();
      tick();

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
